// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset controller: Moore-decoded datapath controls, variable-latency
// memory handshake with bounded wait, illegal-op/timeout trap and retired-instruction count.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCorData,
  output logic [1:0]       RegDst,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUOp,
  output logic             ExtOp,
  output logic             LuiOp,
  output logic             trap,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MADR, S_MRD, S_WBL, S_MWR, S_EXE, S_WBR, S_BR, S_JMP, S_TRAP
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic       is_r, is_jr_fn, is_shift, is_ialu, is_mem, is_br, is_jmp;
  logic       mem_state, timeout, retire;
  logic [2:0] alu_fn;

  always_comb begin
    is_r     = (OpCode == OP_RTYPE);
    is_jr_fn = (Funct == FN_JR) || (Funct == FN_JALR);
    is_shift = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);
    is_ialu  = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_SLTI) ||
               (OpCode == OP_SLTIU) || (OpCode == OP_ANDI) || (OpCode == OP_LUI);
    is_mem   = (OpCode == OP_LW) || (OpCode == OP_SW);
    is_br    = (OpCode == OP_BEQ) || (OpCode == OP_BNE);
    is_jmp   = (OpCode == OP_J) || (OpCode == OP_JAL);

    alu_fn = 3'b000;
    if (is_r)                                          alu_fn = 3'b010;
    else if (is_br)                                    alu_fn = 3'b001;
    else if (OpCode == OP_ANDI)                        alu_fn = 3'b100;
    else if (OpCode == OP_SLTI || OpCode == OP_SLTIU)  alu_fn = 3'b101;
  end

  // A completing access always beats an expiring wait budget.
  assign mem_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign timeout   = mem_state && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IF: begin
        if (mem_ready)    state_d = S_ID;
        else if (timeout) state_d = S_TRAP;
      end
      S_ID: begin
        if (is_r)         state_d = is_jr_fn ? S_JMP : S_EXE;
        else if (is_ialu) state_d = S_EXE;
        else if (is_mem)  state_d = S_MADR;
        else if (is_br)   state_d = S_BR;
        else if (is_jmp)  state_d = S_JMP;
        else              state_d = S_TRAP;
      end
      S_MADR: state_d = (OpCode == OP_SW) ? S_MWR : S_MRD;
      S_MRD: begin
        if (mem_ready)    state_d = S_WBL;
        else if (timeout) state_d = S_TRAP;
      end
      S_MWR: begin
        if (mem_ready)    state_d = S_IF;
        else if (timeout) state_d = S_TRAP;
      end
      S_EXE:   state_d = S_WBR;
      S_WBL, S_WBR, S_BR, S_JMP, S_TRAP: state_d = S_IF;
      default: state_d = S_IF;
    endcase

    if (state_d == S_TRAP && state_q != S_TRAP)
      cause_d = (state_q == S_ID) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;

    // Wait budget restarts on every state change and only burns while stalled.
    if (state_d != state_q)           wait_d = '0;
    else if (mem_state && !mem_ready) wait_d = wait_q + WAIT_W'(1);
    else                              wait_d = wait_q;

    retire = (state_d == S_IF) &&
             ((state_q == S_WBL) || (state_q == S_MWR) || (state_q == S_WBR) ||
              (state_q == S_BR)  || (state_q == S_JMP));
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    PCorData    = 1'b0;
    RegDst      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 4'b0000;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    trap        = 1'b0;
    // Reset forces every control low at once, so an aborted instruction leaves no enable behind.
    if (!reset) begin
      ALUOp[3] = OpCode[0];
      if (state_q != S_IF && state_q != S_ID) ALUOp[2:0] = alu_fn;
      ExtOp = !((OpCode == OP_ANDI) || (OpCode == OP_SLTIU));
      LuiOp = (OpCode == OP_LUI);
      unique case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_ID:   ALUSrcB = 2'b11;
        S_MADR: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_MRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_WBL: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MWR: begin
          MemWrite = !timeout;
          IorD     = 1'b1;
        end
        S_EXE: begin
          if (!is_r) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
          end else if (is_shift) begin
            ALUSrcA = 2'b10;
          end else begin
            ALUSrcA = 2'b01;
          end
        end
        S_WBR: begin
          RegWrite = 1'b1;
          RegDst   = is_r ? 2'b01 : 2'b00;
        end
        S_BR: begin
          PCWriteCond = 1'b1;
          BranchNe    = OpCode[0];
          ALUSrcA     = 2'b01;
          PCSource    = 2'b01;
        end
        S_JMP: begin
          PCWrite = 1'b1;
          if (is_r) begin
            PCSource = 2'b01;
            if (Funct == FN_JALR) begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              PCorData = 1'b1;
            end
          end else begin
            PCSource = 2'b11;
            if (OpCode == OP_JAL) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              PCorData = 1'b1;
            end
          end
        end
        S_TRAP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          trap     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cause   = cause_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT=3): walks each instruction class through its
// states, checking the Moore control word, ALUOp, cause and retired count cycle by cycle.
module tb_mc_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode, Funct;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, PCorData, ExtOp, LuiOp, trap;
  logic [1:0]  RegDst, ALUSrcA, ALUSrcB, PCSource, cause;
  logic [3:0]  ALUOp;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] E_PCW  = 10'b1000000000;
  localparam logic [9:0] E_PCWC = 10'b0100000000;
  localparam logic [9:0] E_BNE  = 10'b0010000000;
  localparam logic [9:0] E_IORD = 10'b0001000000;
  localparam logic [9:0] E_MR   = 10'b0000100000;
  localparam logic [9:0] E_MW   = 10'b0000010000;
  localparam logic [9:0] E_IRW  = 10'b0000001000;
  localparam logic [9:0] E_M2R  = 10'b0000000100;
  localparam logic [9:0] E_RW   = 10'b0000000010;
  localparam logic [9:0] E_PCD  = 10'b0000000001;

  mc_ctrl_fsm #(.MEM_TIMEOUT(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .PCorData(PCorData), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .trap(trap), .cause(cause), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [18:0] ctl_obs;
  assign ctl_obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegWrite, PCorData, RegDst, ALUSrcA, ALUSrcB, PCSource, trap};

  function automatic logic [18:0] ctl(input logic [9:0] en, input logic [1:0] rd,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] ps, input logic t);
    return {en, rd, sa, sb, ps, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; OpCode = 6'h00; Funct = 6'h00; mem_ready = 1'b0;
    #2;
    chk("reset_ctl", ctl_obs, ctl(10'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    chk("reset_retired", retired, 0);
    chk("reset_cause", cause, 2'b00);
    tick(); tick();
    chk("reset_ctl_held", ctl_obs, ctl(10'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    reset = 1'b0;

    // add: IF, ID, EXE, WBR with zero-wait memory
    OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b1; #1;
    chk("add_if", ctl_obs, ctl(E_PCW | E_MR | E_IRW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    tick();
    chk("add_id", ctl_obs, ctl(10'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0));
    chk("add_id_aluop", ALUOp, 4'b0000);
    tick();
    chk("add_exe", ctl_obs, ctl(10'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
    chk("add_exe_aluop", ALUOp, 4'b0010);
    tick();
    chk("add_wbr", ctl_obs, ctl(E_RW, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
    chk("add_wbr_retired", retired, 0);
    tick();
    chk("add_retired", retired, 1);

    // lw with three wait cycles in MRD; ready arrives exactly at the timeout count
    OpCode = 6'h23; Funct = 6'h00; mem_ready = 1'b1; #1;
    chk("lw_if", ctl_obs, ctl(E_PCW | E_MR | E_IRW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    tick();
    chk("lw_id", ctl_obs, ctl(10'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0));
    tick();
    chk("lw_madr", ctl_obs, ctl(10'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0));
    chk("lw_madr_aluop", ALUOp, 4'b1000);
    tick();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw_mrd_wait%0d", i), ctl_obs,
          ctl(E_IORD | E_MR, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("lw_mrd_last", ctl_obs, ctl(E_IORD | E_MR, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    tick();
    chk("lw_wbl", ctl_obs, ctl(E_M2R | E_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    tick();
    chk("lw_retired", retired, 2);
    chk("lw_back_if", ctl_obs, ctl(E_PCW | E_MR | E_IRW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));

    // bne
    OpCode = 6'h05; #1;
    tick(); tick();
    chk("bne_br", ctl_obs, ctl(E_PCWC | E_BNE, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0));
    chk("bne_aluop", ALUOp, 4'b1001);
    tick();
    chk("bne_retired", retired, 3);
    chk("bne_next_if", ctl_obs, ctl(E_PCW | E_MR | E_IRW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));

    // jal then jalr
    OpCode = 6'h03; #1;
    tick(); tick();
    chk("jal_jmp", ctl_obs, ctl(E_PCW | E_RW | E_PCD, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0));
    tick();
    OpCode = 6'h00; Funct = 6'h09; #1;
    tick(); tick();
    chk("jalr_jmp", ctl_obs, ctl(E_PCW | E_RW | E_PCD, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0));
    chk("jalr_extop", {ExtOp, LuiOp}, 2'b10);
    tick();
    chk("jumps_retired", retired, 5);

    // andi: I-type execute, zero-extended immediate, writeback to rt
    OpCode = 6'h0c; Funct = 6'h00; #1;
    tick(); tick();
    chk("andi_exe", ctl_obs, ctl(10'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0));
    chk("andi_aluop", ALUOp, 4'b0100);
    chk("andi_extop", {ExtOp, LuiOp}, 2'b00);
    tick();
    chk("andi_wbr", ctl_obs, ctl(E_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    tick();

    // sw with zero-wait memory
    OpCode = 6'h2b; #1;
    tick(); tick(); tick();
    chk("sw_mwr", ctl_obs, ctl(E_IORD | E_MW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    tick();
    chk("sw_retired", retired, 7);

    // illegal opcode
    OpCode = 6'h3f; #1;
    tick(); tick();
    chk("ill_trap", ctl_obs, ctl(E_PCW, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    chk("ill_cause", cause, 2'b01);
    chk("ill_retired", retired, 7);
    tick();
    chk("ill_trap_done", trap, 1'b0);
    chk("ill_cause_held", cause, 2'b01);

    // fetch timeout: IRWrite must stay low for all four IF cycles
    OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_if%0d", i), ctl_obs, ctl(E_MR, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
      tick();
    end
    chk("to_trap", ctl_obs, ctl(E_PCW, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    chk("to_cause", cause, 2'b10);
    tick();
    chk("to_retired", retired, 7);

    // reset mid-lw while stalled in MRD
    OpCode = 6'h23; mem_ready = 1'b1; #1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    chk("rst_mrd", ctl_obs, ctl(E_IORD | E_MR, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    reset = 1'b1; #1;
    chk("rst_async_ctl", ctl_obs, ctl(10'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    chk("rst_async_retired", retired, 0);
    chk("rst_async_cause", cause, 2'b00);
    tick();
    reset = 1'b0; mem_ready = 1'b1; #1;
    chk("rst_refetch", ctl_obs, ctl(E_PCW | E_MR | E_IRW, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
